// File: rtl/pic8259a_pkg.sv
// Shared types, constants and rotate helpers for the 8259A interrupt acknowledge core.
package pic8259a_pkg;

  localparam int IRQ_COUNT   = 8;
  localparam int INDEX_WIDTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_ACK2  = 2'd3
  } state_t;

  localparam logic EOI_NON_SPECIFIC = 1'b0;
  localparam logic EOI_SPECIFIC     = 1'b1;

  function automatic logic [7:0] rotate_right(input logic [7:0] value, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {value, value} >> amount;
    return doubled[7:0];
  endfunction

  function automatic logic [7:0] rotate_left(input logic [7:0] value, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {value, value} << amount;
    return doubled[15:8];
  endfunction

endpackage

// File: rtl/priority_resolver_8259a.sv
// Rotating priority encoder: the first set bit after i_lowest_priority (wrapping) wins.
module priority_resolver_8259a
  import pic8259a_pkg::*;
(
  input  logic [7:0] i_vector,
  input  logic [2:0] i_lowest_priority,
  output logic [7:0] o_one_hot,
  output logic [2:0] o_index,
  output logic       o_valid
);

  logic [2:0] w_shift;
  logic [7:0] w_rotated;
  logic [2:0] w_rot_index;

  // Rotate so the highest-priority level lands on bit 0, then find the lowest set bit.
  always_comb begin
    w_shift     = i_lowest_priority + 3'd1;
    w_rotated   = rotate_right(i_vector, w_shift);
    w_rot_index = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_rotated[i]) w_rot_index = 3'(i);
    end
    o_valid   = |i_vector;
    o_index   = w_rot_index + w_shift;
    o_one_hot = o_valid ? (8'b1 << o_index) : 8'b0;
  end

endmodule

// File: rtl/interrupt_ack_sequencer_8259a.sv
// 8259A control core: priority arbitration against the ISR, INT generation,
// the two-pulse 8086 INTA sequence, ISR ownership, rotation and EOI handling.
module interrupt_ack_sequencer_8259a
  import pic8259a_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt_request_register,
  input  logic [7:0] interrupt_mask,
  input  logic       interrupt_acknowledge_n,
  input  logic       auto_eoi_config,
  input  logic       rotate_on_auto_eoi,
  input  logic [4:0] vector_base,
  input  logic       eoi_strobe,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  output logic       interrupt_to_cpu,
  output logic       freeze,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] in_service_register,
  output logic [7:0] vector_out,
  output logic       vector_out_enable,
  output state_t     debug_state,
  output logic [2:0] debug_lowest_priority
);

  state_t     r_state, w_state_next;
  logic       r_inta_n_d;
  logic       r_int, w_int_next;
  logic       r_freeze, w_freeze_next;
  logic [7:0] r_clear, w_clear_next;
  logic [7:0] r_isr, w_isr_next;
  logic [7:0] r_vector, w_vector_next;
  logic       r_vec_en, w_vec_en_next;
  logic [2:0] r_level, w_level_next;
  logic       r_spurious, w_spurious_next;
  logic [2:0] r_lowest, w_lowest_next;

  logic [7:0] w_pending;
  logic [7:0] w_req_one_hot, w_isr_one_hot;
  logic [2:0] w_req_index, w_isr_index;
  logic       w_req_valid, w_isr_valid;
  logic [2:0] w_req_rank, w_isr_rank;
  logic       w_request_valid;
  logic       w_inta_fall, w_inta_rise;
  logic [7:0] w_isr_set, w_eoi_clear, w_aeoi_clear;
  logic       w_aeoi_rotate, w_eoi_did_clear;
  logic [2:0] w_eoi_cleared_level;

  assign w_pending = interrupt_request_register & ~interrupt_mask;

  priority_resolver_8259a u_request_resolver (
    .i_vector          (w_pending),
    .i_lowest_priority (r_lowest),
    .o_one_hot         (w_req_one_hot),
    .o_index           (w_req_index),
    .o_valid           (w_req_valid)
  );

  priority_resolver_8259a u_service_resolver (
    .i_vector          (r_isr),
    .i_lowest_priority (r_lowest),
    .o_one_hot         (w_isr_one_hot),
    .o_index           (w_isr_index),
    .o_valid           (w_isr_valid)
  );

  // Rank 0 is the highest priority under the current rotation.
  assign w_req_rank      = w_req_index - r_lowest - 3'd1;
  assign w_isr_rank      = w_isr_index - r_lowest - 3'd1;
  assign w_request_valid = w_req_valid && (!w_isr_valid || (w_req_rank < w_isr_rank));

  assign w_inta_fall = r_inta_n_d & ~interrupt_acknowledge_n;
  assign w_inta_rise = ~r_inta_n_d & interrupt_acknowledge_n;

  always_comb begin
    w_state_next    = r_state;
    w_int_next      = 1'b0;
    w_freeze_next   = r_freeze;
    w_clear_next    = 8'b0;
    w_vector_next   = r_vector;
    w_vec_en_next   = r_vec_en;
    w_level_next    = r_level;
    w_spurious_next = r_spurious;
    w_isr_set       = 8'b0;
    w_aeoi_clear    = 8'b0;
    w_aeoi_rotate   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_int_next = w_request_valid;
        if (w_inta_fall) begin
          w_state_next  = ST_ACK1;
          w_freeze_next = 1'b1;
          w_int_next    = 1'b0;
          if (w_request_valid) begin
            w_level_next    = w_req_index;
            w_spurious_next = 1'b0;
            w_isr_set       = w_req_one_hot;
            w_clear_next    = w_req_one_hot;
          end else begin
            w_level_next    = 3'd7;
            w_spurious_next = 1'b1;
          end
        end
      end
      ST_ACK1: begin
        if (w_inta_rise) w_state_next = ST_WAIT2;
      end
      ST_WAIT2: begin
        if (w_inta_fall) begin
          w_state_next  = ST_ACK2;
          w_vector_next = {vector_base, r_level};
          w_vec_en_next = 1'b1;
        end
      end
      ST_ACK2: begin
        if (w_inta_rise) begin
          w_state_next  = ST_IDLE;
          w_vec_en_next = 1'b0;
          w_freeze_next = 1'b0;
          if (auto_eoi_config && !r_spurious) begin
            w_aeoi_clear  = 8'b1 << r_level;
            w_aeoi_rotate = rotate_on_auto_eoi;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // EOI commands act in every state; a specific EOI always names a level to rotate to.
  always_comb begin
    w_eoi_clear         = 8'b0;
    w_eoi_did_clear     = 1'b0;
    w_eoi_cleared_level = 3'd0;
    if (eoi_strobe) begin
      if (eoi_specific == EOI_SPECIFIC) begin
        w_eoi_clear         = 8'b1 << eoi_level;
        w_eoi_cleared_level = eoi_level;
        w_eoi_did_clear     = 1'b1;
      end else if (w_isr_valid) begin
        w_eoi_clear         = w_isr_one_hot;
        w_eoi_cleared_level = w_isr_index;
        w_eoi_did_clear     = 1'b1;
      end
    end
    w_isr_next = (r_isr & ~w_eoi_clear & ~w_aeoi_clear) | w_isr_set;
    if (eoi_strobe && eoi_rotate && w_eoi_did_clear) w_lowest_next = w_eoi_cleared_level;
    else if (w_aeoi_rotate)                          w_lowest_next = r_level;
    else                                             w_lowest_next = r_lowest;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_inta_n_d <= 1'b1;
      r_int      <= 1'b0;
      r_freeze   <= 1'b0;
      r_clear    <= 8'b0;
      r_isr      <= 8'b0;
      r_vector   <= 8'b0;
      r_vec_en   <= 1'b0;
      r_level    <= 3'd0;
      r_spurious <= 1'b0;
      r_lowest   <= 3'd7;
    end else begin
      r_state    <= w_state_next;
      r_inta_n_d <= interrupt_acknowledge_n;
      r_int      <= w_int_next;
      r_freeze   <= w_freeze_next;
      r_clear    <= w_clear_next;
      r_isr      <= w_isr_next;
      r_vector   <= w_vector_next;
      r_vec_en   <= w_vec_en_next;
      r_level    <= w_level_next;
      r_spurious <= w_spurious_next;
      r_lowest   <= w_lowest_next;
    end
  end

  assign interrupt_to_cpu        = r_int;
  assign freeze                  = r_freeze;
  assign clear_interrupt_request = r_clear;
  assign in_service_register     = r_isr;
  assign vector_out              = r_vector;
  assign vector_out_enable       = r_vec_en;
  assign debug_state             = r_state;
  assign debug_lowest_priority   = r_lowest;

endmodule

// File: tb/tb_interrupt_ack_sequencer_8259a.sv
// Directed bench for the 8259A acknowledge core: hand-computed expectations per scenario.
module tb_interrupt_ack_sequencer_8259a;
  import pic8259a_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] interrupt_request_register;
  logic [7:0] interrupt_mask;
  logic       interrupt_acknowledge_n;
  logic       auto_eoi_config;
  logic       rotate_on_auto_eoi;
  logic [4:0] vector_base;
  logic       eoi_strobe;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic       interrupt_to_cpu;
  logic       freeze;
  logic [7:0] clear_interrupt_request;
  logic [7:0] in_service_register;
  logic [7:0] vector_out;
  logic       vector_out_enable;
  state_t     debug_state;
  logic [2:0] debug_lowest_priority;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_ack_sequencer_8259a dut (
    .clock                      (clock),
    .reset                      (reset),
    .interrupt_request_register (interrupt_request_register),
    .interrupt_mask             (interrupt_mask),
    .interrupt_acknowledge_n    (interrupt_acknowledge_n),
    .auto_eoi_config            (auto_eoi_config),
    .rotate_on_auto_eoi         (rotate_on_auto_eoi),
    .vector_base                (vector_base),
    .eoi_strobe                 (eoi_strobe),
    .eoi_specific               (eoi_specific),
    .eoi_rotate                 (eoi_rotate),
    .eoi_level                  (eoi_level),
    .interrupt_to_cpu           (interrupt_to_cpu),
    .freeze                     (freeze),
    .clear_interrupt_request    (clear_interrupt_request),
    .in_service_register        (in_service_register),
    .vector_out                 (vector_out),
    .vector_out_enable          (vector_out_enable),
    .debug_state                (debug_state),
    .debug_lowest_priority      (debug_lowest_priority)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset                      = 1'b1;
    interrupt_request_register = 8'h00;
    interrupt_mask             = 8'h00;
    interrupt_acknowledge_n    = 1'b1;
    auto_eoi_config            = 1'b0;
    rotate_on_auto_eoi         = 1'b0;
    vector_base                = 5'h08;
    eoi_strobe                 = 1'b0;
    eoi_specific               = 1'b0;
    eoi_rotate                 = 1'b0;
    eoi_level                  = 3'd0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // drivers
  task automatic inta_step(input logic level);
    interrupt_acknowledge_n = level;
    tick();
  endtask

  task automatic full_ack();
    inta_step(1'b0);
    inta_step(1'b0);
    inta_step(1'b1);
    inta_step(1'b0);
    inta_step(1'b1);
  endtask

  task automatic eoi_cmd(input logic specific, input logic rotate, input logic [2:0] level);
    eoi_strobe   = 1'b1;
    eoi_specific = specific;
    eoi_rotate   = rotate;
    eoi_level    = level;
    tick();
    eoi_strobe   = 1'b0;
    eoi_rotate   = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    n_checks++;
    if ({interrupt_to_cpu, freeze, vector_out_enable} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {interrupt_to_cpu, freeze, vector_out_enable});
    end
    n_checks++;
    if ({clear_interrupt_request, in_service_register, vector_out} !== 24'h0) begin
      n_fail++; $display("FAIL reset_buses: got %h expected 000000", {clear_interrupt_request, in_service_register, vector_out});
    end
    n_checks++;
    if (debug_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d expected %0d", debug_state, ST_IDLE);
    end
    n_checks++;
    if (debug_lowest_priority !== 3'd7) begin
      n_fail++; $display("FAIL reset_lowest: got %0d expected 7", debug_lowest_priority);
    end
  endtask

  task automatic test_basic_ack();
    reset_dut();
    interrupt_request_register = 8'h05;
    n_checks++;
    if (interrupt_to_cpu !== 1'b0) begin
      n_fail++; $display("FAIL int_latency_pre: got %b expected 0", interrupt_to_cpu);
    end
    tick();
    n_checks++;
    if (interrupt_to_cpu !== 1'b1) begin
      n_fail++; $display("FAIL int_raise: got %b expected 1", interrupt_to_cpu);
    end
    inta_step(1'b0);
    n_checks++;
    if ({freeze, interrupt_to_cpu, in_service_register, clear_interrupt_request} !== {2'b10, 8'h01, 8'h01}) begin
      n_fail++; $display("FAIL ack1_outputs: got %b %b %h %h expected 1 0 01 01", freeze, interrupt_to_cpu, in_service_register, clear_interrupt_request);
    end
    n_checks++;
    if (debug_state !== ST_ACK1) begin
      n_fail++; $display("FAIL ack1_state: got %0d expected %0d", debug_state, ST_ACK1);
    end
    inta_step(1'b0);
    n_checks++;
    if (clear_interrupt_request !== 8'h00) begin
      n_fail++; $display("FAIL clear_one_cycle: got %h expected 00", clear_interrupt_request);
    end
    inta_step(1'b1);
    n_checks++;
    if (debug_state !== ST_WAIT2 || vector_out_enable !== 1'b0) begin
      n_fail++; $display("FAIL wait2: got state %0d en %b expected %0d 0", debug_state, vector_out_enable, ST_WAIT2);
    end
    inta_step(1'b0);
    n_checks++;
    if (vector_out !== 8'h40 || vector_out_enable !== 1'b1) begin
      n_fail++; $display("FAIL ack2_vector: got %h en %b expected 40 1", vector_out, vector_out_enable);
    end
    inta_step(1'b1);
    n_checks++;
    if ({vector_out_enable, freeze, in_service_register} !== {2'b00, 8'h01} || debug_state !== ST_IDLE) begin
      n_fail++; $display("FAIL ack_end: got en %b frz %b isr %h state %0d expected 0 0 01 %0d", vector_out_enable, freeze, in_service_register, debug_state, ST_IDLE);
    end
    interrupt_request_register = 8'h04;
    tick();
    tick();
    n_checks++;
    if (interrupt_to_cpu !== 1'b0) begin
      n_fail++; $display("FAIL int_blocked_by_isr0: got %b expected 0", interrupt_to_cpu);
    end
  endtask

  task automatic test_isr_priority_and_nseoi();
    reset_dut();
    interrupt_request_register = 8'h04;
    tick();
    full_ack();
    interrupt_request_register = 8'h08;
    tick();
    tick();
    n_checks++;
    if (in_service_register !== 8'h04 || interrupt_to_cpu !== 1'b0) begin
      n_fail++; $display("FAIL lower_blocked: got isr %h int %b expected 04 0", in_service_register, interrupt_to_cpu);
    end
    interrupt_request_register = 8'h02;
    tick();
    n_checks++;
    if (interrupt_to_cpu !== 1'b1) begin
      n_fail++; $display("FAIL higher_nests: got %b expected 1", interrupt_to_cpu);
    end
    full_ack();
    interrupt_request_register = 8'h00;
    n_checks++;
    if (in_service_register !== 8'h06) begin
      n_fail++; $display("FAIL nested_isr: got %h expected 06", in_service_register);
    end
    eoi_cmd(EOI_NON_SPECIFIC, 1'b0, 3'd0);
    n_checks++;
    if (in_service_register !== 8'h04 || debug_lowest_priority !== 3'd7) begin
      n_fail++; $display("FAIL nseoi: got isr %h lp %0d expected 04 7", in_service_register, debug_lowest_priority);
    end
    eoi_cmd(EOI_NON_SPECIFIC, 1'b0, 3'd0);
    eoi_cmd(EOI_NON_SPECIFIC, 1'b1, 3'd0);
    n_checks++;
    if (in_service_register !== 8'h00 || debug_lowest_priority !== 3'd7) begin
      n_fail++; $display("FAIL nseoi_empty: got isr %h lp %0d expected 00 7", in_service_register, debug_lowest_priority);
    end
  endtask

  task automatic test_specific_rotate();
    reset_dut();
    interrupt_request_register = 8'h08;
    tick();
    full_ack();
    interrupt_request_register = 8'h00;
    eoi_cmd(EOI_SPECIFIC, 1'b1, 3'd3);
    n_checks++;
    if (in_service_register !== 8'h00 || debug_lowest_priority !== 3'd3) begin
      n_fail++; $display("FAIL seoi_rotate: got isr %h lp %0d expected 00 3", in_service_register, debug_lowest_priority);
    end
    interrupt_request_register = 8'h11;
    tick();
    full_ack();
    n_checks++;
    if (vector_out !== 8'h44 || in_service_register !== 8'h10) begin
      n_fail++; $display("FAIL rotated_winner: got vec %h isr %h expected 44 10", vector_out, in_service_register);
    end
  endtask

  task automatic test_auto_eoi();
    reset_dut();
    auto_eoi_config    = 1'b1;
    rotate_on_auto_eoi = 1'b1;
    interrupt_request_register = 8'h80;
    tick();
    inta_step(1'b0);
    n_checks++;
    if (in_service_register !== 8'h80) begin
      n_fail++; $display("FAIL aeoi_set: got %h expected 80", in_service_register);
    end
    inta_step(1'b0);
    inta_step(1'b1);
    inta_step(1'b0);
    n_checks++;
    if (vector_out !== 8'h47 || in_service_register !== 8'h80) begin
      n_fail++; $display("FAIL aeoi_vector: got vec %h isr %h expected 47 80", vector_out, in_service_register);
    end
    inta_step(1'b1);
    n_checks++;
    if (in_service_register !== 8'h00 || debug_lowest_priority !== 3'd7) begin
      n_fail++; $display("FAIL aeoi_clear: got isr %h lp %0d expected 00 7", in_service_register, debug_lowest_priority);
    end
    interrupt_request_register = 8'h04;
    tick();
    full_ack();
    n_checks++;
    if (in_service_register !== 8'h00 || debug_lowest_priority !== 3'd2) begin
      n_fail++; $display("FAIL aeoi_rotate: got isr %h lp %0d expected 00 2", in_service_register, debug_lowest_priority);
    end
  endtask

  task automatic test_spurious();
    reset_dut();
    interrupt_request_register = 8'h02;
    tick();
    n_checks++;
    if (interrupt_to_cpu !== 1'b1) begin
      n_fail++; $display("FAIL spur_int: got %b expected 1", interrupt_to_cpu);
    end
    interrupt_request_register = 8'h00;
    inta_step(1'b0);
    n_checks++;
    if ({freeze, interrupt_to_cpu, in_service_register, clear_interrupt_request} !== {2'b10, 16'h0000}) begin
      n_fail++; $display("FAIL spur_ack1: got %b %b %h %h expected 1 0 00 00", freeze, interrupt_to_cpu, in_service_register, clear_interrupt_request);
    end
    inta_step(1'b1);
    inta_step(1'b0);
    n_checks++;
    if (vector_out !== 8'h47 || vector_out_enable !== 1'b1) begin
      n_fail++; $display("FAIL spur_vector: got %h en %b expected 47 1", vector_out, vector_out_enable);
    end
    inta_step(1'b1);
    n_checks++;
    if (in_service_register !== 8'h00 || clear_interrupt_request !== 8'h00) begin
      n_fail++; $display("FAIL spur_end: got isr %h clr %h expected 00 00", in_service_register, clear_interrupt_request);
    end
  endtask

  task automatic test_reset_mid_inta();
    reset_dut();
    interrupt_request_register = 8'h01;
    tick();
    inta_step(1'b0);
    inta_step(1'b1);
    n_checks++;
    if (debug_state !== ST_WAIT2 || freeze !== 1'b1 || in_service_register !== 8'h01) begin
      n_fail++; $display("FAIL pre_reset_wait2: got state %0d frz %b isr %h expected %0d 1 01", debug_state, freeze, in_service_register, ST_WAIT2);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({freeze, vector_out_enable, interrupt_to_cpu, in_service_register} !== {3'b000, 8'h00} || debug_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_mid_inta: got frz %b en %b int %b isr %h state %0d expected 0 0 0 00 %0d", freeze, vector_out_enable, interrupt_to_cpu, in_service_register, debug_state, ST_IDLE);
    end
  endtask

  task automatic test_simultaneous();
    reset_dut();
    interrupt_request_register = 8'h01;
    tick();
    interrupt_acknowledge_n = 1'b0;
    eoi_cmd(EOI_SPECIFIC, 1'b0, 3'd0);
    n_checks++;
    if (in_service_register !== 8'h01) begin
      n_fail++; $display("FAIL set_wins: got %h expected 01", in_service_register);
    end
    inta_step(1'b1);
    inta_step(1'b0);
    interrupt_request_register = 8'h00;
    auto_eoi_config = 1'b1;
    rotate_on_auto_eoi = 1'b1;
    // ISR holds only IR0 here; specific EOI on IR5 with rotate collides with the auto-EOI of IR0.
    interrupt_acknowledge_n = 1'b1;
    eoi_cmd(EOI_SPECIFIC, 1'b1, 3'd5);
    n_checks++;
    if (in_service_register !== 8'h00 || debug_lowest_priority !== 3'd5) begin
      n_fail++; $display("FAIL eoi_and_aeoi: got isr %h lp %0d expected 00 5", in_service_register, debug_lowest_priority);
    end
  endtask

  initial begin
    test_reset();
    test_basic_ack();
    test_isr_priority_and_nseoi();
    test_specific_rotate();
    test_auto_eoi();
    test_spurious();
    test_reset_mid_inta();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
